// File: rtl/axi_lite_master.sv
// AXI4-Lite master bridging single-cycle core requests to the interconnect.
// One read or write per request; busy stalls the core until DONE.
module axi_lite_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [31:0]               wr_data,
  input  logic [3:0]                wr_strobe,
  output logic [31:0]               rd_data,
  output logic                      access_fault,
  output logic                      busy,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW_W = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int CW = (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  logic [2:0]                state;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic                      aw_done;
  logic                      w_done;
  logic [CW-1:0]             cnt;
  logic                      active;
  logic                      tmo;
  logic                      aw_hs;
  logic                      w_hs;

  assign active = (state == S_AR) || (state == S_R) ||
                  (state == S_AW_W) || (state == S_B);

  // All channels are silenced in the timeout cycle so no
  // handshake can race the forced exit to DONE.
  assign tmo = (TIMEOUT_CYCLES != 0) && active && (cnt == TMO);

  assign m_axi_arvalid = (state == S_AR) && !tmo;
  assign m_axi_rready  = (state == S_R) && !tmo;
  assign m_axi_awvalid = (state == S_AW_W) && !aw_done && !tmo;
  assign m_axi_wvalid  = (state == S_AW_W) && !w_done && !tmo;
  assign m_axi_bready  = (state == S_B) && !tmo;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  assign m_axi_araddr = addr_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_arprot = 3'b000;
  assign m_axi_awprot = 3'b000;

  assign busy = (state == S_IDLE) ? (rd_en | wr_en) :
                (state != S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      cnt          <= '0;
      rd_data      <= '0;
      access_fault <= 1'b0;
    end else begin
      cnt <= active ? cnt + 1'b1 : '0;
      if (tmo) begin
        state        <= S_DONE;
        access_fault <= 1'b1;
        rd_data      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (wr_en) begin
              addr_q  <= addr;
              wdata_q <= wr_data;
              wstrb_q <= wr_strobe;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= S_AW_W;
            end else if (rd_en) begin
              addr_q <= addr;
              state  <= S_AR;
            end
          end
          S_AR: begin
            if (m_axi_arready) state <= S_R;
          end
          S_R: begin
            if (m_axi_rvalid) begin
              rd_data      <= (m_axi_rresp == 2'b00) ?
                              m_axi_rdata : 32'h0;
              access_fault <= (m_axi_rresp != 2'b00);
              state        <= S_DONE;
            end
          end
          S_AW_W: begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if ((aw_done || aw_hs) && (w_done || w_hs))
              state <= S_B;
          end
          S_B: begin
            if (m_axi_bvalid) begin
              access_fault <= (m_axi_bresp != 2'b00);
              rd_data      <= '0;
              state        <= S_DONE;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
